spi_flash_responder: RTL and testbench

- Synthesizable SPI NOR flash target that answers the bootloader's SPI master (spi_cs/spi_sck/spi_mosi/spi_miso).
- Used in on-board loopback and emulation builds in place of the physical flash.
- Decodes a read-only subset of the flash command set.
- Serves data from a synchronous 1-cycle-latency byte memory (BRAM) through a simple read port.
- Oversamples SPI in the fabric clock domain; no SPI-clocked logic.

---
 rtl/spi_flash_responder.sv | 197 +++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
// Read-only SPI NOR flash emulator: oversamples a mode-0 SPI bus in the clk domain
// and serves 0x03/0x0B/0x05/0x9F from a 1-cycle-latency byte memory.
module spi_flash_responder #(
    parameter int          ADDR_W   = 24,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016,
    parameter logic [7:0]  STATUS   = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_cs,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              busy,
    output logic              cmd_err
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;
    typedef enum logic [1:0] {MODE_READ, MODE_STATUS, MODE_JEDEC} mode_t;

    state_t      state;
    mode_t       mode;
    logic        fast;
    logic        armed;
    logic        rd_q;
    logic [4:0]  bit_cnt;
    logic [1:0]  jedec_idx;
    logic [7:0]  cmd_sh;
    logic [23:0] addr_sh;
    logic [7:0]  tx_sh;

    logic cs_p0, cs_p1, cs_p2;
    logic sck_p0, sck_p1, sck_p2;
    logic mosi_p0, mosi_p1;

    logic        sck_rise, sck_fall, cs_fall;
    logic [7:0]  cmd_next;
    logic [23:0] addr_next;

    function automatic logic [7:0] jedec_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return JEDEC_ID[23:16];
            2'd1:    return JEDEC_ID[15:8];
            2'd2:    return JEDEC_ID[7:0];
            default: return 8'h00;
        endcase
    endfunction

    // p0/p1: synchronizer, p2: previous sample for edge detection. Deliberately
    // not reset, so a reset with cs already low cannot fabricate a cs falling edge.
    always_ff @(posedge clk) begin
        cs_p0   <= spi_cs;
        cs_p1   <= cs_p0;
        cs_p2   <= cs_p1;
        sck_p0  <= spi_sck;
        sck_p1  <= sck_p0;
        sck_p2  <= sck_p1;
        mosi_p0 <= spi_mosi;
        mosi_p1 <= mosi_p0;
    end

    assign sck_rise  = sck_p1 & ~sck_p2;
    assign sck_fall  = ~sck_p1 & sck_p2;
    assign cs_fall   = ~cs_p1 & cs_p2;
    assign cmd_next  = {cmd_sh[6:0], mosi_p1};
    assign addr_next = {addr_sh[22:0], mosi_p1};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mode      <= MODE_READ;
            fast      <= 1'b0;
            armed     <= 1'b0;
            rd_q      <= 1'b0;
            bit_cnt   <= '0;
            jedec_idx <= '0;
            spi_miso  <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            busy      <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            mem_rd_en <= 1'b0;
            rd_q      <= mem_rd_en;
            busy      <= armed & ~cs_p1;
            // armed only once cs has been seen high since reset, so a transfer
            // that was already running across reset is never decoded
            if (cs_p1)
                armed <= 1'b1;
            if (rd_q)
                tx_sh <= mem_rd_data;

            if (state != IDLE && cs_p1) begin
                state    <= IDLE;
                spi_miso <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        spi_miso <= 1'b0;
                        if (cs_fall && armed) begin
                            state   <= CMD;
                            bit_cnt <= '0;
                        end
                    end
                    CMD: begin
                        if (sck_rise) begin
                            cmd_sh  <= cmd_next;
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= '0;
                                case (cmd_next)
                                    8'h03: begin
                                        state <= ADDR;
                                        mode  <= MODE_READ;
                                        fast  <= 1'b0;
                                    end
                                    8'h0B: begin
                                        state <= ADDR;
                                        mode  <= MODE_READ;
                                        fast  <= 1'b1;
                                    end
                                    8'h05: begin
                                        state <= DATA;
                                        mode  <= MODE_STATUS;
                                        tx_sh <= STATUS;
                                    end
                                    8'h9F: begin
                                        state     <= DATA;
                                        mode      <= MODE_JEDEC;
                                        tx_sh     <= jedec_byte(2'd0);
                                        jedec_idx <= 2'd1;
                                    end
                                    default: begin
                                        state   <= IGNORE;
                                        cmd_err <= 1'b1;
                                    end
                                endcase
                            end
                        end
                    end
                    ADDR: begin
                        if (sck_rise) begin
                            addr_sh <= addr_next;
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd23) begin
                                bit_cnt   <= '0;
                                mem_addr  <= addr_next[ADDR_W-1:0];
                                mem_rd_en <= 1'b1;
                                state     <= fast ? DUMMY : DATA;
                            end
                        end
                    end
                    DUMMY: begin
                        if (sck_rise) begin
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= '0;
                                state   <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (sck_fall) begin
                            spi_miso <= tx_sh[7];
                            tx_sh    <= {tx_sh[6:0], 1'b0};
                        end else if (sck_rise) begin
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= '0;
                                // next byte must be in tx_sh before the following falling edge
                                case (mode)
                                    MODE_READ: begin
                                        mem_addr  <= mem_addr + ADDR_W'(1);
                                        mem_rd_en <= 1'b1;
                                    end
                                    MODE_STATUS: tx_sh <= STATUS;
                                    default: begin
                                        tx_sh <= jedec_byte(jedec_idx);
                                        if (jedec_idx != 2'd3)
                                            jedec_idx <= jedec_idx + 2'd1;
                                    end
                                endcase
                            end
                        end
                    end
                    default: begin
                        spi_miso <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: bit-banged mode-0 master, byte memory
// returning addr[7:0], and monitors for read strobes and miso activity.
module tb_spi_flash_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spi_cs = 1'b1;
    logic        spi_sck = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        mem_rd_en;
    logic [23:0] mem_addr;
    logic [7:0]  mem_rd_data = 8'h00;
    logic        busy;
    logic        cmd_err;

    int n_chk = 0;
    int n_err = 0;

    int          rd_cnt = 0;
    int          b2b_cnt = 0;
    int          miso_hi = 0;
    logic        rd_prev = 1'b0;
    logic [23:0] rd_log [0:63];

    logic [7:0] tx_buf [0:15];
    logic [7:0] rx_buf [0:15];
    logic       busy_mid;

    spi_flash_responder #(
        .ADDR_W   (24),
        .JEDEC_ID (24'hEF4016),
        .STATUS   (8'h5A)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .spi_cs      (spi_cs),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .busy        (busy),
        .cmd_err     (cmd_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= mem_addr[7:0];
            rd_log[rd_cnt % 64] <= mem_addr;
            rd_cnt <= rd_cnt + 1;
            if (rd_prev)
                b2b_cnt <= b2b_cnt + 1;
        end
        rd_prev <= mem_rd_en;
        if (spi_miso)
            miso_hi <= miso_hi + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic half_period();
        repeat (4) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic b, input bit end_cs, output logic r);
        spi_mosi = b;
        half_period();
        r = spi_miso;
        spi_sck = 1'b1;
        if (end_cs)
            spi_cs = 1'b1;
        half_period();
        spi_sck = 1'b0;
    endtask

    // The last rising edge coincides with cs rising, so the responder drops it.
    task automatic run_txn(input int nbits);
        logic r;
        for (int i = 0; i < 16; i++)
            rx_buf[i] = 8'h00;
        spi_cs = 1'b0;
        half_period();
        busy_mid = busy;
        for (int k = 0; k < nbits; k++) begin
            bit_xfer(tx_buf[k / 8][7 - (k % 8)], k == nbits - 1, r);
            rx_buf[k / 8][7 - (k % 8)] = r;
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic set_tx(input logic [63:0] v);
        logic [63:0] t;
        t = v;
        for (int i = 0; i < 8; i++)
            tx_buf[i] = t[63 - 8*i -: 8];
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          rd0;
        int          mh0;
        logic        r;
        logic [7:0]  jed [0:4];
        jed[0] = 8'hEF; jed[1] = 8'h40; jed[2] = 8'h16; jed[3] = 8'h00; jed[4] = 8'h00;

        repeat (6) @(negedge clk);
        chk("rst_miso", spi_miso, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_err", cmd_err, 0);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        // JEDEC ID, 5 response bytes
        rd0 = rd_cnt;
        set_tx(64'h9F00000000000000);
        run_txn(48);
        chk("jedec_busy", busy_mid, 1);
        chk("jedec_cmd_miso", rx_buf[0], 8'h00);
        for (int i = 0; i < 5; i++)
            chk($sformatf("jedec_b%0d", i), rx_buf[i + 1], jed[i]);
        chk("jedec_rd_cnt", rd_cnt - rd0, 0);
        chk("idle_busy", busy, 0);

        // Normal read from 0x000100
        rd0 = rd_cnt;
        set_tx(64'h0300010000000000);
        run_txn(64);
        for (int i = 0; i < 4; i++)
            chk($sformatf("read_b%0d", i), rx_buf[i + 4], i);
        chk("read_rd_cnt", rd_cnt - rd0, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("read_addr%0d", i), rd_log[(rd0 + i) % 64], 24'h000100 + i);

        // Fast read across the top of the address space
        rd0 = rd_cnt;
        set_tx(64'h0BFFFFFE00000000);
        run_txn(64);
        chk("fast_b0", rx_buf[5], 8'hFE);
        chk("fast_b1", rx_buf[6], 8'hFF);
        chk("fast_b2", rx_buf[7], 8'h00);
        chk("fast_rd_cnt", rd_cnt - rd0, 3);
        chk("fast_addr0", rd_log[rd0 % 64], 24'hFFFFFE);
        chk("fast_addr1", rd_log[(rd0 + 1) % 64], 24'hFFFFFF);
        chk("fast_addr2", rd_log[(rd0 + 2) % 64], 24'h000000);

        // Status register, repeated
        set_tx(64'h05FFFFFF00000000);
        run_txn(32);
        for (int i = 0; i < 3; i++)
            chk($sformatf("status_b%0d", i), rx_buf[i + 1], 8'h5A);

        // Unsupported opcode, then a normal JEDEC read
        rd0 = rd_cnt;
        mh0 = miso_hi;
        chk("pre_cmd_err", cmd_err, 0);
        set_tx(64'hC7FFFF0000000000);
        run_txn(24);
        chk("bad_cmd_err", cmd_err, 1);
        chk("bad_miso_hi", miso_hi - mh0, 0);
        chk("bad_rd_cnt", rd_cnt - rd0, 0);
        set_tx(64'h9F00000000000000);
        run_txn(32);
        for (int i = 0; i < 3; i++)
            chk($sformatf("after_bad_b%0d", i), rx_buf[i + 1], jed[i]);
        chk("err_sticky", cmd_err, 1);

        // Read aborted after 12 address bits
        rd0 = rd_cnt;
        set_tx(64'h0300100000000000);
        run_txn(20);
        chk("abort_rd_cnt", rd_cnt - rd0, 0);
        chk("abort_miso", spi_miso, 0);

        // Reset in the middle of the next transfer; rest of it must be ignored
        spi_cs = 1'b0;
        half_period();
        bit_xfer(1'b1, 1'b0, r);
        bit_xfer(1'b0, 1'b0, r);
        bit_xfer(1'b0, 1'b0, r);
        bit_xfer(1'b1, 1'b0, r);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_miso", spi_miso, 0);
        chk("midrst_cmd_err", cmd_err, 0);
        mh0 = miso_hi;
        for (int k = 0; k < 20; k++)
            bit_xfer(k < 4, 1'b0, r);
        chk("midrst_miso_hi", miso_hi - mh0, 0);
        chk("midrst_busy_late", busy, 0);
        spi_cs = 1'b1;
        repeat (8) @(negedge clk);
        chk("midrst_rd_cnt", rd_cnt - rd0, 0);

        set_tx(64'h9F00000000000000);
        run_txn(16);
        chk("post_rst_jedec", rx_buf[1], 8'hEF);
        chk("no_b2b_rd_en", b2b_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
